bist_scan_sequencer: RTL and testbench

Sequencer for the self-test path around the scan-inserted circuit. It drives the scan-enable and test-mode mux select, steps the pattern LFSR, and enables and clears the output MISR. After a fixed number of shift/capture patterns it compares the MISR signature against a golden value and reports pass/fail. It replaces the free-running start/end controller with a pattern-counted, chain-length-aware schedule.

---
 rtl/bist_scan_sequencer_if.sv | 54 +++++
 rtl/bist_scan_sequencer.sv | 142 ++++++++++++++
 tb/tb_bist_scan_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bist_scan_sequencer_if.sv
// ----------------------------------------------------------------------------
// bist_scan_sequencer_if
// Groups the run control and self-test strobes of bist_scan_sequencer.
//   master : test controller side (drives start/abort/sig_in, observes strobes)
//   slave  : sequencer side (observes start/abort/sig_in, drives strobes)
// Signals:
//   start      run request
//   abort      cancel the run (only when BIST_ABORT_EN is defined)
//   sig_in     MISR signature
//   bist_mode  test-mode mux select (1 = LFSR drives circuit inputs)
//   scan_en    scan shift enable
//   lfsr_load  LFSR seed reload strobe
//   lfsr_en    LFSR advance
//   misr_clr   MISR clear strobe
//   misr_en    MISR compaction enable
//   busy       run in progress
//   bist_end   run complete, result valid
//   pass_fail  1 = signature matched
// Optional feature macro: BIST_ABORT_EN
// ----------------------------------------------------------------------------
interface bist_scan_sequencer_if #(
    parameter int SIG_W = 3
);
    logic             start;
`ifdef BIST_ABORT_EN
    logic             abort;
`endif
    logic [SIG_W-1:0] sig_in;
    logic             bist_mode;
    logic             scan_en;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_clr;
    logic             misr_en;
    logic             busy;
    logic             bist_end;
    logic             pass_fail;

`ifdef BIST_ABORT_EN
    modport master (output start, abort, sig_in,
                    input  bist_mode, scan_en, lfsr_load, lfsr_en, misr_clr,
                           misr_en, busy, bist_end, pass_fail);
    modport slave  (input  start, abort, sig_in,
                    output bist_mode, scan_en, lfsr_load, lfsr_en, misr_clr,
                           misr_en, busy, bist_end, pass_fail);
`else
    modport master (output start, sig_in,
                    input  bist_mode, scan_en, lfsr_load, lfsr_en, misr_clr,
                           misr_en, busy, bist_end, pass_fail);
    modport slave  (input  start, sig_in,
                    output bist_mode, scan_en, lfsr_load, lfsr_en, misr_clr,
                           misr_en, busy, bist_end, pass_fail);
`endif
endinterface

// File: rtl/bist_scan_sequencer.sv
// ----------------------------------------------------------------------------
// bist_scan_sequencer
// Pattern-counted BIST schedule: INIT, N_PATTERNS x (CHAIN_LEN shifts +
// 1 capture), CHAIN_LEN-cycle unload, signature compare, DONE.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   io_bus   bist_scan_sequencer_if.slave (run control, strobes, result)
// Optional feature macro: BIST_ABORT_EN (adds abort; cancels an active run)
// All strobes are Moore-decoded from state; pass_fail is a register.
// ----------------------------------------------------------------------------
module bist_scan_sequencer #(
    parameter int               CHAIN_LEN  = 4,
    parameter int               N_PATTERNS = 8,
    parameter int               SIG_W      = 3,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 3'b101
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    bist_scan_sequencer_if.slave  io_bus
);
    localparam int CW = (CHAIN_LEN  > 1) ? $clog2(CHAIN_LEN)  : 1;
    localparam int PW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_shift_cnt;
    logic [PW-1:0]   r_pat_cnt;
    logic            r_pass_fail;
    logic            w_bist_mode, w_scan_en, w_lfsr_load, w_lfsr_en;
    logic            w_misr_clr, w_misr_en, w_busy, w_bist_end;
    logic            w_abort;
    logic            w_shift_last, w_pat_last;

`ifdef BIST_ABORT_EN
    assign w_abort = io_bus.abort & w_busy;
`else
    assign w_abort = 1'b0;
`endif

    assign w_shift_last = (r_shift_cnt == CW'(CHAIN_LEN - 1));
    assign w_pat_last   = (r_pat_cnt   == PW'(N_PATTERNS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_bist_mode = 1'b0;
        w_scan_en   = 1'b0;
        w_lfsr_load = 1'b0;
        w_lfsr_en   = 1'b0;
        w_misr_clr  = 1'b0;
        w_misr_en   = 1'b0;
        w_bist_end  = 1'b0;
        case (r_state)
            S_IDLE: if (io_bus.start) w_next = S_INIT;
            S_INIT: begin
                w_lfsr_load = 1'b1;
                w_misr_clr  = 1'b1;
                w_bist_mode = 1'b1;
                w_next      = S_SHIFT;
            end
            S_SHIFT: begin
                w_scan_en   = 1'b1;
                w_bist_mode = 1'b1;
                w_lfsr_en   = 1'b1;
                w_misr_en   = 1'b1;
                if (w_shift_last) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_bist_mode = 1'b1;
                w_lfsr_en   = 1'b1;
                w_misr_en   = 1'b1;
                w_next      = w_pat_last ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                // LFSR frozen: only the last capture is shifted out
                w_scan_en   = 1'b1;
                w_bist_mode = 1'b1;
                w_misr_en   = 1'b1;
                if (w_shift_last) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                w_bist_mode = 1'b1;
                w_next      = S_DONE;
            end
            S_DONE: begin
                w_bist_end = 1'b1;
                // held start must not relaunch; wait for it to drop
                if (!io_bus.start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_pass_fail <= 1'b0;
        end else if (w_abort) begin
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_pass_fail <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_shift_cnt <= '0;
                    r_pat_cnt   <= '0;
                    r_pass_fail <= 1'b0;
                end
                // shift counter is shared by the shift and unload bursts
                S_SHIFT, S_UNLOAD:
                    r_shift_cnt <= w_shift_last ? '0 : r_shift_cnt + 1'b1;
                S_CAPTURE:
                    if (!w_pat_last) r_pat_cnt <= r_pat_cnt + 1'b1;
                S_COMPARE:
                    r_pass_fail <= (io_bus.sig_in == GOLDEN_SIG);
                default: ;
            endcase
        end
    end

    assign io_bus.bist_mode = w_bist_mode;
    assign io_bus.scan_en   = w_scan_en;
    assign io_bus.lfsr_load = w_lfsr_load;
    assign io_bus.lfsr_en   = w_lfsr_en;
    assign io_bus.misr_clr  = w_misr_clr;
    assign io_bus.misr_en   = w_misr_en;
    assign io_bus.busy      = w_busy;
    assign io_bus.bist_end  = w_bist_end;
    assign io_bus.pass_fail = r_pass_fail;
endmodule

// File: tb/tb_bist_scan_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bist_scan_sequencer
// Two DUTs share stimulus: default config (4x8) and CHAIN_LEN=1,N_PATTERNS=1.
// A cycle-offset model (time since INIT) predicts every strobe; literal
// latency/pulse-count expectations pin the model. Latency is counted from the
// edge that samples start in IDLE: 1 INIT + N*(C+1) + C unload + 1 compare
// edges, so DONE is visible after edge N*(C+1)+C+2 (46 default, 5 small).
// ----------------------------------------------------------------------------
module tb_bist_scan_sequencer;
    localparam int NDUT = 2;
    localparam int MC[NDUT] = '{4, 1};
    localparam int MN[NDUT] = '{8, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] sig = 3'b000;
    int         checks = 0;
    int         errors = 0;
    int         ecnt = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    bist_scan_sequencer_if #(.SIG_W(3)) if0 ();
    bist_scan_sequencer_if #(.SIG_W(3)) if1 ();
    assign if0.start = start;  assign if1.start = start;
    assign if0.sig_in = sig;   assign if1.sig_in = sig;
`ifdef BIST_ABORT_EN
    assign if0.abort = abort;  assign if1.abort = abort;
`endif

    bist_scan_sequencer dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(if0));
    bist_scan_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(if1));

    // {bist_mode, scan_en, lfsr_load, lfsr_en, misr_clr, misr_en, busy, bist_end}
    logic [7:0] dut_o [NDUT];
    logic       dut_pf[NDUT];
    assign dut_o[0] = {if0.bist_mode, if0.scan_en, if0.lfsr_load, if0.lfsr_en,
                       if0.misr_clr, if0.misr_en, if0.busy, if0.bist_end};
    assign dut_o[1] = {if1.bist_mode, if1.scan_en, if1.lfsr_load, if1.lfsr_en,
                       if1.misr_clr, if1.misr_en, if1.busy, if1.bist_end};
    assign dut_pf[0] = if0.pass_fail;
    assign dut_pf[1] = if1.pass_fail;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: run phase + cycles since INIT ----------------
    int m_run[NDUT];   // 0 idle, 1 running, 2 done
    int m_t  [NDUT];
    bit m_pf [NDUT];

    function automatic logic [7:0] exp_o(input int run, input int t,
                                         input int c, input int n);
        int body = n * (c + 1);
        if (run == 0) return 8'b0000_0000;
        if (run == 2) return 8'b0000_0001;
        if (t == 0) return 8'b1010_1010;                          // seed/clear
        if (t <= body) return (((t - 1) % (c + 1)) < c) ? 8'b1101_0110  // shift
                                                        : 8'b1001_0110; // capture
        if (t <= body + c) return 8'b1100_0110;                   // unload
        return 8'b1000_0010;                                      // compare
    endfunction

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                m_run[i] <= 0; m_t[i] <= 0; m_pf[i] <= 1'b0;
            end
`ifdef BIST_ABORT_EN
            else if (abort && m_run[i] == 1) begin
                m_run[i] <= 0; m_pf[i] <= 1'b0;
            end
`endif
            else if (m_run[i] == 0) begin
                if (start) begin m_run[i] <= 1; m_t[i] <= 0; end
            end else if (m_run[i] == 1) begin
                if (m_t[i] == 0) m_pf[i] <= 1'b0;
                if (m_t[i] == MN[i] * (MC[i] + 1) + MC[i] + 1) begin
                    m_pf[i]  <= (sig == 3'b101);
                    m_run[i] <= 2;
                end else m_t[i] <= m_t[i] + 1;
            end else if (!start) m_run[i] <= 0;
        end
    end

    // ---------------- compare + pulse monitors ----------------
    int  n_lfsr[NDUT], n_misr[NDUT], n_scanr[NDUT], n_endr[NDUT], rise_e[NDUT];
    bit  prev_scan[NDUT], prev_end[NDUT];

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (chk_en) begin
                check($sformatf("dut%0d_strobes", i), int'(dut_o[i]),
                      int'(exp_o(m_run[i], m_t[i], MC[i], MN[i])));
                check($sformatf("dut%0d_pass_fail", i), int'(dut_pf[i]), int'(m_pf[i]));
            end
            if (dut_o[i][4]) n_lfsr[i]++;
            if (dut_o[i][2]) n_misr[i]++;
            if (dut_o[i][6] && !prev_scan[i]) n_scanr[i]++;
            if (dut_o[i][0] && !prev_end[i]) begin n_endr[i]++; rise_e[i] = ecnt; end
            prev_scan[i] = dut_o[i][6];
            prev_end[i]  = dut_o[i][0];
        end
    end

    // ---------------- directed stimulus ----------------
    int e0;

    task automatic pulse_start(input logic [2:0] s);
        sig = s;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 e0 = ecnt;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_run(input logic [2:0] s, input int exp_pf);
        int l0 = n_lfsr[0], l1 = n_lfsr[1], m0 = n_misr[0], m1 = n_misr[1];
        int s0 = n_scanr[0], s1 = n_scanr[1];
        int k = 0;
        pulse_start(s);
        while (!if0.bist_end && k < 100) begin @(negedge clk); k++; end
        #1;
        check("run_timeout", int'(k < 100), 1);
        check("latency_default", rise_e[0] - e0, 46);
        check("latency_small", rise_e[1] - e0, 5);
        check("lfsr_en_cycles_default", n_lfsr[0] - l0, 40);
        check("misr_en_cycles_default", n_misr[0] - m0, 44);
        check("scan_bursts_default", n_scanr[0] - s0, 9);
        check("lfsr_en_cycles_small", n_lfsr[1] - l1, 2);
        check("misr_en_cycles_small", n_misr[1] - m1, 3);
        check("scan_bursts_small", n_scanr[1] - s1, 2);
        check("pass_fail_done", int'(if0.pass_fail), exp_pf);
        check("bist_end_done", int'(if0.bist_end), 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'(dut_o[0]), 0);
        check("reset_pass_fail", int'(if0.pass_fail), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_run(3'b101, 1);
        do_run(3'b100, 0);
        do_run(3'b101, 1);

        // held start: DONE persists, no relaunch
        @(negedge clk) start = 1'b1;
        repeat (60) @(negedge clk);
        check("held_bist_end", int'(if0.bist_end), 1);
        check("held_busy", int'(if0.busy), 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("drop_start_bist_end", int'(if0.bist_end), 0);

        // reset asserted at edge 20 of a run
        pulse_start(3'b101);
        while (ecnt < e0 + 19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset_outputs", int'(dut_o[0]), 0);
        check("midrun_reset_pass_fail", int'(if0.pass_fail), 0);
        @(negedge clk) rst_n = 1'b1;
        do_run(3'b101, 1);

`ifdef BIST_ABORT_EN
        begin
            int r0;
            pulse_start(3'b101);
            r0 = n_endr[0];
            while (ecnt < e0 + 9) @(negedge clk);
            abort = 1'b1;
            @(posedge clk); #1;
            check("abort_busy", int'(if0.busy), 0);
            check("abort_pass_fail", int'(if0.pass_fail), 0);
            @(negedge clk) abort = 1'b0;
            repeat (60) @(negedge clk);
            check("abort_no_bist_end", n_endr[0] - r0, 0);
            start = 1'b1;
            repeat (60) @(negedge clk);
            abort = 1'b1;
            repeat (3) @(negedge clk);
            check("abort_in_done_ignored", int'(if0.bist_end), 1);
            abort = 1'b0;
            start = 1'b0;
            repeat (2) @(negedge clk);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
